voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic note scheduler for the synth's fixed bank of `voice` oscillators. It accepts note-on/note-off requests over a valid/ready handshake and assigns each note to a voice: the lowest free voice first, otherwise it steals the oldest sounding voice. It drives every voice's `gate` and `pitch_increment`. It sits between the note source (CPU register block or button decoder) and the voice/mixer chain, so note patterns no longer need hard-wiring.

## Interface
- `NUM_VOICES`, 8, number of voices managed (2..16)
- `PITCH_W`, 16, pitch-increment width, matching the voice `pitch_increment` input
- `AGE_W`, 8, width of the saturating per-voice age counter
- `STEAL_GAP`, 256, clk cycles gate is held low on a stolen voice (one sample period at SAMPLECLOCK_DIV=8)

- `clk`  in  1  system clock (8 MHz domain)
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_on`  in  1  1 = note-on, 0 = note-off
- `req_pitch`  in  PITCH_W  pitch increment of the note
- `req_ready`  out  1  allocator can accept a request
- `panic`  in  1  all-notes-off, synchronous, highest priority
- `gate`  out  NUM_VOICES  per-voice gate, bit i drives voice i
- `pitch`  out  NUM_VOICES*PITCH_W  voice i's pitch in bits [i*PITCH_W +: PITCH_W]
- `stolen`  out  1  one-clk pulse when a note-on stole a voice

## Operation
- Internal state per voice: `gate`, `pitch`, and `age` (AGE_W bits).
- FSM states: IDLE, SCAN, COMMIT, GAP. `req_ready` = (state == IDLE).
- Accept: `req_valid && req_ready` at a rising edge. The allocator latches `req_on`/`req_pitch`, sets idx=0 and moves to SCAN.
- SCAN visits voice idx on each cycle, idx 0..NUM_VOICES-1, then goes to COMMIT. It tracks:
  - match: lowest i with gate[i] && pitch[i]==req_pitch.
  - free: lowest i with !gate[i].
  - oldest: gated i with the largest age; ties go to the lowest i.
- COMMIT for note-on, in priority order:
  - match found: age[match] := 0; gate and pitch unchanged (no retrigger); then IDLE.
  - free found: gate := 1, pitch := req_pitch, age := 0 for that voice; then IDLE.
  - otherwise: steal the oldest voice. Set pitch := req_pitch, age := 0, gate := 0, `stolen` = 1 for this cycle. Load the gap counter with STEAL_GAP-1 and go to GAP.
  - In the free and steal cases, every other gated voice's age increments, saturating at 2^AGE_W-1. The match case does not touch other ages.
- COMMIT for note-off:
  - match found: gate[match] := 0; age and pitch unchanged.
  - no match: no state change.
  - Then IDLE.
- GAP: the counter decrements each cycle. When it reaches 0, set gate[victim] := 1 and go to IDLE.
- `panic` at any rising edge, in any state:
  - all gates := 0, all ages := 0, state := IDLE, `stolen` := 0.
  - pitches are retained.
  - any in-flight request is dropped.
  - `panic` wins over a simultaneous accept.
- Ungated voices do not age.

## Timing
- Reset values: state IDLE, `req_ready` 1, `gate` all 0, `pitch` all 0, ages 0, `stolen` 0.
- Latency for edge 0 = accept edge:
  - edges 1..NUM_VOICES are SCAN.
  - edge NUM_VOICES+1 is COMMIT; new gate/pitch are visible after it.
  - `req_ready` returns high after that edge, or after GAP ends.
- Throughput: one request per NUM_VOICES+2 clks (non-steal).
- Steal: gate[victim] is low for exactly STEAL_GAP clks. Pitch changes at the same edge the gate falls.
- `req_pitch`/`req_on` only need to be valid at the accept edge.
- `req_valid` held high while `req_ready` is low has no effect.
- Reset asserted mid-operation returns to reset values immediately, asynchronously. Release is synchronous to `clk`.

## Test plan
- Reset, then note-on 29528 → after 10 clks (N=8): gate=0x01, pitch[0]=29528, `req_ready` high.
- Note-ons 29528, 26306, 22121 → gates 0x07. Note-off 26306 → gate=0x05. Next note-on 35115 → voice 1, gate=0x07.
- Fill all 8 voices with distinct pitches, then note-on 13935 → `stolen` pulses, voice 0 pitch=13935. gate[0] is low for exactly 256 clks, then high. The next steal takes voice 1.
- Note-on 29528 twice → second request is a match: gate unchanged, only one voice gated.
- Note-off for a pitch not sounding → gates unchanged, ready after 10 clks.
- `panic` asserted during SCAN and during GAP → gates 0 next edge, `req_ready` 1. Async reset during GAP → all outputs at reset values without a clk edge.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note-request handshake between a note source and the voice allocator.
// The source presents a note-on/off with its pitch increment; the allocator
// accepts it on a clock edge where both valid and ready are high.
interface voice_allocator_if #(
    parameter int PITCH_W = 16
);
    logic               req_valid;
    logic               req_on;
    logic [PITCH_W-1:0] req_pitch;
    logic               req_ready;

    modport master (
        output req_valid,
        output req_on,
        output req_pitch,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_on,
        input  req_pitch,
        output req_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note-ons to the lowest free voice,
// otherwise steals the oldest sounding voice (with a gate-low gap so the
// envelope retriggers), and releases voices on matching note-offs.
// A request is scanned one voice per clock, then committed in one cycle.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int PITCH_W    = 16,
    parameter int AGE_W      = 8,
    parameter int STEAL_GAP  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    voice_allocator_if.slave              bus,
    input  logic                          panic,
    output logic [NUM_VOICES-1:0]         gate,
    output logic [NUM_VOICES*PITCH_W-1:0] pitch,
    output logic                          stolen
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = (STEAL_GAP > 1) ? $clog2(STEAL_GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(STEAL_GAP - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, GAP} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               do_steal;

    logic [NUM_VOICES-1:0] gate_q;
    logic [PITCH_W-1:0]    pitch_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_q   [NUM_VOICES];

    logic               req_on_q;
    logic [PITCH_W-1:0] req_pitch_q;
    logic [IDX_W-1:0]   idx;
    logic               match_found, free_found, old_found;
    logic [IDX_W-1:0]   match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]   old_age;
    logic [CNT_W-1:0]   gap_cnt;

    function automatic logic [AGE_W-1:0] age_inc_sat(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + AGE_ONE;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; panic overrides everything, including a pending accept.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_steal  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) state_nxt = COMMIT;
            end
            COMMIT: begin
                do_steal  = req_on_q && !match_found && !free_found;
                state_nxt = do_steal ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (panic) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            do_steal  = 1'b0;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign gate          = gate_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pitch
        assign pitch[g*PITCH_W +: PITCH_W] = pitch_q[g];
    end

    // Request latch, per-voice scan trackers, voice state update and steal gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_q      <= '0;
            stolen      <= 1'b0;
            req_on_q    <= 1'b0;
            req_pitch_q <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
            gap_cnt     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                pitch_q[i] <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            stolen <= 1'b0;
            if (panic) begin
                gate_q <= '0;
                for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            req_on_q    <= bus.req_on;
                            req_pitch_q <= bus.req_pitch;
                            idx         <= '0;
                            match_found <= 1'b0;
                            free_found  <= 1'b0;
                            old_found   <= 1'b0;
                        end
                    end
                    SCAN: begin
                        if (!match_found && gate_q[idx] && pitch_q[idx] == req_pitch_q) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        if (!free_found && !gate_q[idx]) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        // Strictly-greater keeps the lowest index on equal ages.
                        if (gate_q[idx] && (!old_found || age_q[idx] > old_age)) begin
                            old_found <= 1'b1;
                            old_idx   <= idx;
                            old_age   <= age_q[idx];
                        end
                        idx <= idx + IDX_ONE;
                    end
                    COMMIT: begin
                        if (req_on_q) begin
                            if (match_found) begin
                                age_q[match_idx] <= '0;
                            end else begin
                                for (int i = 0; i < NUM_VOICES; i++)
                                    if (gate_q[i]) age_q[i] <= age_inc_sat(age_q[i]);
                                // Later writes to the chosen voice override the ageing above.
                                if (free_found) begin
                                    gate_q[free_idx]  <= 1'b1;
                                    pitch_q[free_idx] <= req_pitch_q;
                                    age_q[free_idx]   <= '0;
                                end else begin
                                    gate_q[old_idx]  <= 1'b0;
                                    pitch_q[old_idx] <= req_pitch_q;
                                    age_q[old_idx]   <= '0;
                                    stolen           <= 1'b1;
                                    gap_cnt          <= GAP_LOAD;
                                end
                            end
                        end else if (match_found) begin
                            gate_q[match_idx] <= 1'b0;
                        end
                    end
                    GAP: begin
                        // old_idx still holds the victim: trackers are idle until the next accept.
                        if (gap_cnt == '0) gate_q[old_idx] <= 1'b1;
                        else               gap_cnt <= gap_cnt - CNT_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a request-level model predicts gate/pitch/stolen/
// ready every cycle, plus directed hand-computed checks of key outcomes.
module tb_voice_allocator;
    localparam int N       = 8;
    localparam int PW      = 16;
    localparam int AW      = 8;
    localparam int GAPLEN  = 256;
    localparam int AGE_SAT = (1 << AW) - 1;
    localparam int TMO     = 2000;

    logic          clk    = 1'b0;
    logic          rst    = 1'b0;
    logic          panic  = 1'b0;
    logic [N-1:0]  gate;
    logic [N*PW-1:0] pitch;
    logic          stolen;

    voice_allocator_if #(.PITCH_W(PW)) bus ();

    voice_allocator #(
        .NUM_VOICES(N), .PITCH_W(PW), .AGE_W(AW), .STEAL_GAP(GAPLEN)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .panic(panic),
        .gate(gate), .pitch(pitch), .stolen(stolen)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] pv(input int i);
        return pitch[i*PW +: PW];
    endfunction

    // ---------------- request-level model ----------------
    bit            m_gate  [N];
    logic [PW-1:0] m_pitch [N];
    int            m_age   [N];
    bit            m_stolen;
    int            m_wait, m_gap, m_victim;
    bit            m_on;
    logic [PW-1:0] m_req;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0; m_pitch[i] = '0; m_age[i] = 0;
        end
        m_stolen = 0; m_wait = 0; m_gap = 0; m_victim = 0; m_on = 0; m_req = '0;
    endtask

    task automatic m_commit();
        int hit, fr, old;
        hit = -1; fr = -1; old = -1;
        for (int i = 0; i < N; i++) begin
            if (hit < 0 && m_gate[i] && m_pitch[i] == m_req) hit = i;
            if (fr < 0 && !m_gate[i]) fr = i;
            if (m_gate[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
        end
        if (!m_on) begin
            if (hit >= 0) m_gate[hit] = 0;
        end else if (hit >= 0) begin
            m_age[hit] = 0;
        end else begin
            int v;
            v = (fr >= 0) ? fr : old;
            for (int i = 0; i < N; i++)
                if (m_gate[i] && i != v && m_age[i] < AGE_SAT) m_age[i]++;
            m_pitch[v] = m_req;
            m_age[v]   = 0;
            if (fr >= 0) m_gate[v] = 1;
            else begin
                m_gate[v] = 0; m_stolen = 1; m_gap = GAPLEN; m_victim = v;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else begin
                m_stolen = 0;
                if (panic) begin
                    for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_age[i] = 0; end
                    m_wait = 0; m_gap = 0;
                end else if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) m_commit();
                end else if (m_gap > 0) begin
                    m_gap--;
                    if (m_gap == 0) m_gate[m_victim] = 1;
                end else if (bus.req_valid) begin
                    m_on = bus.req_on; m_req = bus.req_pitch; m_wait = N + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare and gate[0] / stolen monitor ----------------
    int stolen_cnt = 0;
    int low_run    = 0;
    int last_run   = 0;

    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            logic [N*PW-1:0] ep;
            logic [N-1:0]    eg;
            for (int i = 0; i < N; i++) begin
                ep[i*PW +: PW] = m_pitch[i];
                eg[i]          = m_gate[i];
            end
            check("cyc_gate",   gate,          eg);
            check("cyc_pitch",  pitch,         ep);
            check("cyc_stolen", stolen,        m_stolen);
            check("cyc_ready",  bus.req_ready, (m_wait == 0 && m_gap == 0));
            if (stolen) stolen_cnt++;
            if (!gate[0]) low_run++;
            else begin
                if (low_run > 0) last_run = low_run;
                low_run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic accept_req(input bit on, input logic [PW-1:0] p, input int hold);
        int t;
        t = 0;
        while (!bus.req_ready && t < TMO) begin @(negedge clk); t++; end
        if (!bus.req_ready) check("accept_timeout", 0, 1);
        bus.req_valid = 1'b1; bus.req_on = on; bus.req_pitch = p;
        @(negedge clk);
        repeat (hold) begin
            bus.req_on = ~on; bus.req_pitch = ~p;
            @(negedge clk);
        end
        bus.req_valid = 1'b0; bus.req_on = ~on; bus.req_pitch = 16'hdead;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!bus.req_ready && lat < TMO) begin @(negedge clk); lat++; end
        if (!bus.req_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input bit on, input logic [PW-1:0] p, output int lat);
        accept_req(on, p, 0);
        wait_ready(lat);
    endtask

    task automatic fill(input int base);
        int l;
        for (int i = 0; i < N; i++) begin
            if (i == 0) begin
                accept_req(1'b1, PW'(base), 3);
                wait_ready(l);
            end else send(1'b1, PW'(base + i * 100), l);
        end
    endtask

    task automatic panic_pulse();
        panic = 1'b1;
        @(negedge clk);
        panic = 1'b0;
    endtask

    initial begin
        int lat, sc;
        bus.req_valid = 1'b0; bus.req_on = 1'b0; bus.req_pitch = '0;
        #1;
        check("rst_gate",   gate,          0);
        check("rst_ready",  bus.req_ready, 1);
        check("rst_stolen", stolen,        0);
        check("rst_pitch",  pitch,         0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // first note goes to voice 0; ready returns N+1 negedges after the accept edge
        send(1'b1, 16'd29528, lat);
        check("on1_latency", lat, N + 1);
        check("on1_gate",    gate, 8'h01);
        check("on1_pitch0",  pv(0), 16'd29528);

        send(1'b1, 16'd26306, lat);
        send(1'b1, 16'd22121, lat);
        check("three_gate", gate, 8'h07);
        send(1'b0, 16'd26306, lat);
        check("off_gate", gate, 8'h05);
        send(1'b1, 16'd35115, lat);
        check("reuse_gate",   gate, 8'h07);
        check("reuse_pitch1", pv(1), 16'd35115);

        // repeated note-on matches the sounding voice
        send(1'b1, 16'd29528, lat);
        check("match_gate",    gate, 8'h07);
        check("match_latency", lat, N + 1);

        // note-off for a pitch that is not sounding
        send(1'b0, 16'd12345, lat);
        check("offmiss_gate",    gate, 8'h07);
        check("offmiss_latency", lat, N + 1);

        panic_pulse();
        check("panic_idle_gate", gate, 8'h00);

        // fill all voices (first request holds valid through SCAN), then steal
        fill(1000);
        check("fill_gate", gate, 8'hff);
        sc = stolen_cnt;
        send(1'b1, 16'd13935, lat);
        @(negedge clk);
        check("steal_latency", lat, N + 1 + GAPLEN);
        check("steal_pitch0",  pv(0), 16'd13935);
        check("steal_gate",    gate, 8'hff);
        check("steal_pulses",  stolen_cnt - sc, 1);
        check("steal_lowrun",  last_run, GAPLEN);

        // voice 1 is now the oldest
        send(1'b1, 16'd7777, lat);
        @(negedge clk);
        check("steal2_pitch1", pv(1), 16'd7777);
        check("steal2_pitch0", pv(0), 16'd13935);
        check("steal2_pulses", stolen_cnt - sc, 2);

        // panic during SCAN
        accept_req(1'b1, 16'd5000, 0);
        repeat (2) @(negedge clk);
        panic_pulse();
        check("pscan_gate",  gate, 8'h00);
        check("pscan_ready", bus.req_ready, 1);

        // panic during GAP
        fill(2000);
        accept_req(1'b1, 16'd9999, 0);
        repeat (N + 20) @(negedge clk);
        panic_pulse();
        check("pgap_gate",   gate, 8'h00);
        check("pgap_ready",  bus.req_ready, 1);
        check("pgap_stolen", stolen, 0);
        check("pgap_pitch0", pv(0), 16'd9999);

        // asynchronous reset during GAP, observed before any clock edge
        fill(3000);
        accept_req(1'b1, 16'd8888, 0);
        repeat (N + 30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_gate",   gate, 8'h00);
        check("arst_ready",  bus.req_ready, 1);
        check("arst_stolen", stolen, 0);
        check("arst_pitch",  pitch, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        send(1'b1, 16'd29528, lat);
        check("post_rst_gate",   gate, 8'h01);
        check("post_rst_pitch0", pv(0), 16'd29528);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
